vga_timing_gen: RTL

//  Free-running 640x480@60 VGA raster timing generator for the demo top level.

---
 rtl/vga_timing_gen.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Free-running raster timing generator (640x480@60 by default) for the demo
// top level. It produces registered pixel coordinates, sync, blanking and
// line/frame pulses for the warp-effect renderer and the uo_out pin packer.
//
// Ports
//   clk          in   1   pixel clock (25.175 MHz tile clock)
//   rst_n        in   1   asynchronous active-low reset, synchronous release
//   ena          in   1   advance enable; low freezes all state
//   hpos         out  10  current column, 0..H_TOTAL-1
//   vpos         out  10  current line,   0..V_TOTAL-1
//   display_on   out  1   high inside the visible window
//   hsync        out  1   SYNC_POL level during the horizontal sync window
//   vsync        out  1   SYNC_POL level during the vertical sync window
//   line_start   out  1   one-cycle pulse in the cycle hpos shows 0 after a wrap
//   frame_start  out  1   one-cycle pulse in the cycle (hpos,vpos) shows (0,0)
//                         after a full wrap
//   frame_cnt    out  8   frame counter (modulo 256), warp animation phase
//
// Build option
//   VGA_TIMING_SYNC_DELAY_EN : when defined, hsync, vsync and display_on go
//   through a RENDER_LAT-deep shift register (advanced with ena) so they line
//   up with renderer RGB that lags hpos/vpos by RENDER_LAT clocks. hpos, vpos,
//   the pulses and frame_cnt are never delayed. When undefined, RENDER_LAT is
//   unused.
//
// Handshake: there is none; ena is a plain clock enable. When ena is high on a
// rising clk edge the raster advances by one pixel; when low, everything
// holds and the single-cycle pulses read 0.
//
// H_TOTAL and V_TOTAL must each be <= 1024 so the 10-bit counters cover them.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_DISP     = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_DISP     = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned SYNC_POL   = 0,
    parameter int unsigned RENDER_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    // -------------------------------------------------------------------------
    // Derived constants. Window bounds are kept 11 bits wide so an end bound
    // equal to 1024 still compares correctly against a 10-bit counter.
    // -------------------------------------------------------------------------
    localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_DISP_END   = 11'(H_DISP);
    localparam logic [10:0] V_DISP_END   = 11'(V_DISP);
    localparam logic [10:0] H_SYNC_BEGIN = 11'(H_DISP + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_DISP + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEGIN = 11'(V_DISP + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_DISP + V_FP + V_SYNC);

    localparam logic SYNC_ACT  = (SYNC_POL != 0);
    localparam logic SYNC_IDLE = ~SYNC_ACT;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    logic [9:0] hpos_q,  hpos_d;
    logic [9:0] vpos_q,  vpos_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       display_on_q, display_on_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;

    logic       h_wrap;
    logic       v_wrap;
    logic       frame_wrap;
    logic       hs_win;
    logic       vs_win;
    logic       de_win;

    // -------------------------------------------------------------------------
    // Next-state counters
    // -------------------------------------------------------------------------
    always_comb begin
        h_wrap     = (hpos_q == H_LAST);
        v_wrap     = (vpos_q == V_LAST);
        frame_wrap = h_wrap && v_wrap;

        hpos_d = h_wrap ? 10'd0 : hpos_q + 10'd1;

        vpos_d = vpos_q;
        if (h_wrap) begin
            vpos_d = v_wrap ? 10'd0 : vpos_q + 10'd1;
        end

        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Decode from the next-state coordinates so the registered decode lands in
    // the same cycle as the coordinates it describes.
    // -------------------------------------------------------------------------
    always_comb begin
        hs_win = ({1'b0, hpos_d} >= H_SYNC_BEGIN) && ({1'b0, hpos_d} < H_SYNC_END);
        vs_win = ({1'b0, vpos_d} >= V_SYNC_BEGIN) && ({1'b0, vpos_d} < V_SYNC_END);
        de_win = ({1'b0, hpos_d} < H_DISP_END) && ({1'b0, vpos_d} < V_DISP_END);

        hsync_d       = hs_win ? SYNC_ACT : SYNC_IDLE;
        vsync_d       = vs_win ? SYNC_ACT : SYNC_IDLE;
        display_on_d  = de_win;
        line_start_d  = h_wrap;
        frame_start_d = frame_wrap;
    end

    // -------------------------------------------------------------------------
    // Register update. display_on resets low even though (0,0) is visible:
    // nothing is shown until the raster actually starts moving.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos_q        <= 10'd0;
            vpos_q        <= 10'd0;
            frame_cnt_q   <= 8'd0;
            hsync_q       <= SYNC_IDLE;
            vsync_q       <= SYNC_IDLE;
            display_on_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (ena) begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_cnt_q   <= frame_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            display_on_q  <= display_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end else begin
            // Frozen: level outputs hold, pulses must not repeat.
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Undelayed outputs
    // -------------------------------------------------------------------------
    assign hpos        = hpos_q;
    assign vpos        = vpos_q;
    assign frame_cnt   = frame_cnt_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_SYNC_DELAY_EN
    // -------------------------------------------------------------------------
    // Optional alignment delay for sync and blanking.
    // -------------------------------------------------------------------------
    generate
        if (RENDER_LAT == 0) begin : g_no_lat
            assign hsync      = hsync_q;
            assign vsync      = vsync_q;
            assign display_on = display_on_q;
        end else begin : g_lat
            logic [RENDER_LAT-1:0] hs_pipe_q;
            logic [RENDER_LAT-1:0] vs_pipe_q;
            logic [RENDER_LAT-1:0] de_pipe_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_pipe_q <= {RENDER_LAT{SYNC_IDLE}};
                    vs_pipe_q <= {RENDER_LAT{SYNC_IDLE}};
                    de_pipe_q <= '0;
                end else if (ena) begin
                    hs_pipe_q[0] <= hsync_q;
                    vs_pipe_q[0] <= vsync_q;
                    de_pipe_q[0] <= display_on_q;
                    for (int i = 1; i < int'(RENDER_LAT); i++) begin
                        hs_pipe_q[i] <= hs_pipe_q[i-1];
                        vs_pipe_q[i] <= vs_pipe_q[i-1];
                        de_pipe_q[i] <= de_pipe_q[i-1];
                    end
                end
            end

            assign hsync      = hs_pipe_q[RENDER_LAT-1];
            assign vsync      = vs_pipe_q[RENDER_LAT-1];
            assign display_on = de_pipe_q[RENDER_LAT-1];
        end
    endgenerate
`else
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = display_on_q;
`endif

    // -------------------------------------------------------------------------
    // Structural properties: counters stay in range and pulses are coherent.
    // -------------------------------------------------------------------------
    a_hpos_range : assert property (@(posedge clk) disable iff (!rst_n)
        hpos_q <= H_LAST);
    a_vpos_range : assert property (@(posedge clk) disable iff (!rst_n)
        vpos_q <= V_LAST);
    a_frame_implies_line : assert property (@(posedge clk) disable iff (!rst_n)
        frame_start_q |-> line_start_q);
    a_line_at_col0 : assert property (@(posedge clk) disable iff (!rst_n)
        line_start_q |-> (hpos_q == 10'd0));

endmodule
